// File: rtl/elastic_pipe_pkg.sv
// Shared types and helpers for the elastic valid/ready pipeline.
package elastic_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic int occ_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/elastic_pipeline_stage.sv
// One skid-buffer stage: main + skid register, all handshake outputs decoded from state flops.
//
// state | meaning
// EMPTY | main and skid invalid
// BUSY  | main valid, skid invalid
// FULL  | main and skid valid, upstream stalled
module elastic_stage
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    stage_state_t          state;
    stage_state_t          state_nxt;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain case exists
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        out_data  = main_q;
    end

    // Payload registers carry no reset; validity lives entirely in the state.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// Chain of NUM_STAGES skid-buffer stages giving full throughput with registered valid/ready.
// Define ELASTIC_PIPE_OCC_EN to add the registered occupancy output occ.
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef ELASTIC_PIPE_OCC_EN
    ,
    output logic [occ_width(NUM_STAGES)-1:0] occ
`endif
);

    logic                  vld [NUM_STAGES+1];
    logic                  rdy [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] dat [NUM_STAGES+1];

    assign vld[0]          = in_valid;
    assign dat[0]          = in_data;
    assign in_ready        = rdy[0];
    assign out_valid       = vld[NUM_STAGES];
    assign out_data        = dat[NUM_STAGES];
    assign rdy[NUM_STAGES] = out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        elastic_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .in_valid (vld[i]),
            .in_data  (dat[i]),
            .in_ready (rdy[i]),
            .out_valid(vld[i+1]),
            .out_data (dat[i+1]),
            .out_ready(rdy[i+1])
        );
    end

`ifdef ELASTIC_PIPE_OCC_EN
    localparam int            OW      = occ_width(NUM_STAGES);
    localparam logic [OW-1:0] OCC_MAX = OW'(2 * NUM_STAGES);

    logic          top_in_fire;
    logic          top_out_fire;
    logic [OW-1:0] occ_q;

    assign top_in_fire  = in_valid && in_ready;
    assign top_out_fire = out_valid && out_ready;
    assign occ          = occ_q;

    // Simultaneous push and pop leaves the count untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q <= '0;
        end else if (top_in_fire && !top_out_fire) begin
            occ_q <= occ_q + OW'(1);
        end else if (!top_in_fire && top_out_fire) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    a_occ_max: assert property (@(posedge clk) disable iff (!rstn) occ_q <= OCC_MAX);
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: queue scoreboard plus directed stream/stall/reset/random phases.
module tb_elastic_pipeline;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    logic        in_valid1;
    logic [15:0] in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic [15:0] out_data1;
    logic        out_ready1;

`ifdef ELASTIC_PIPE_OCC_EN
    logic [2:0] occ;
    logic [1:0] occ1;
`endif

    elastic_pipeline #(.NUM_STAGES(3), .DATA_WIDTH(16)) u_dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef ELASTIC_PIPE_OCC_EN
        , .occ(occ)
`endif
    );

    elastic_pipeline #(.NUM_STAGES(1), .DATA_WIDTH(16)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1)
`ifdef ELASTIC_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_ov = -1;
    logic [15:0] q[$];
    logic [15:0] got[$];
    int out_edges[$];
    logic hold_prev = 1'b0;
    logic [15:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: words leave in the order they entered, held while stalled, at most 6 inside.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                check("sb_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) check("out_data", out_data, q[0]);
                if (first_ov < 0) first_ov = cyc;
            end
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            check("capacity", 32'(q.size() <= 6), 1);
`ifdef ELASTIC_PIPE_OCC_EN
            check("occ", occ, q.size());
`endif
            if (out_valid && out_ready && q.size() > 0) begin
                got.push_back(q.pop_front());
                out_edges.push_back(cyc + 1);
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                if (first_acc < 0) first_acc = cyc + 1;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(q.size() == 0 && !out_valid), 1);
    endtask

    initial begin
        int acc;
        int sent;
        int guard;
        rstn = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Streaming 0x0001..0x0010 unstalled
        out_ready = 1'b1;
        got.delete(); out_edges.delete();
        first_acc = -1; first_ov = -1;
        for (int i = 1; i <= 16; i++) send(16'(i));
        wait_drain("stream_drain", 40);
        check("stream_latency", first_ov - first_acc, 2);
        check("stream_count", got.size(), 16);
        check("stream_first", got[0], 16'h0001);
        check("stream_last", got[15], 16'h0010);
        check("stream_no_bubble", out_edges[15] - out_edges[0], 15);

        // Full stall
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_accepted", acc, 6);
        check("stall_in_ready", in_ready, 0);
        check("stall_model_size", q.size(), 6);
`ifdef ELASTIC_PIPE_OCC_EN
        check("stall_occ", occ, 6);
`endif

        // Release
        got.delete(); out_edges.delete();
        out_ready = 1'b1;
        wait_drain("release_drain", 30);
        check("release_count", got.size(), 6);
        for (int k = 0; k < 6; k++) check("release_word", got[k], 16'hA000 + 16'(k));
        check("release_no_bubble", out_edges[5] - out_edges[0], 5);

        // Reset with 4 words in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'hC000 + 16'(i));
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
`ifdef ELASTIC_PIPE_OCC_EN
        check("midrst_occ", occ, 0);
`endif
        q.delete(); got.delete(); out_edges.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_rel_in_ready", in_ready, 1);
        check("midrst_rel_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'hB000);
        wait_drain("midrst_drain", 20);
        check("midrst_count", got.size(), 1);
        check("midrst_first", got[0], 16'hB000);

        // Random traffic
        got.delete(); out_edges.delete();
        sent = 0; guard = 0;
        while (sent < 10000 && guard < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'h1000 + 16'(sent);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 10000);
        wait_drain("rand_drain", 40);
        check("rand_received", got.size(), 10000);

        // Single-stage instance
        out_ready1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1 = 16'h0D01;
        @(negedge clk);
        check("n1_ready0", in_ready1, 1);
        @(posedge clk);
        #1;
        in_data1 = 16'h0D02;
        @(negedge clk);
        check("n1_latency_valid", out_valid1, 1);
        check("n1_latency_data", out_data1, 16'h0D01);
        check("n1_ready1", in_ready1, 1);
        @(posedge clk);
        #1;
        in_data1 = 16'h0D03;
        repeat (3) begin
            @(negedge clk);
            check("n1_full", in_ready1, 0);
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;
`ifdef ELASTIC_PIPE_OCC_EN
        check("n1_occ", occ1, 2);
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        check("n1_out0_valid", out_valid1, 1);
        check("n1_out0_data", out_data1, 16'h0D01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("n1_out1_valid", out_valid1, 1);
        check("n1_out1_data", out_data1, 16'h0D02);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("n1_empty", out_valid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
